mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Bus-side controller between the 6502 core's memory request port and the 64kB behavioural memory.
- Accepts byte read, byte write and 16-bit little-endian word read requests over a valid/ready handshake.
- Drives the memory's enable/address/write strobes and holds them stable for the memory's registered-read latency plus programmable wait states.
- Returns captured read data with a single-cycle response strobe.

Parameters:
- ADDR_WIDTH, 16, address width; memory depth is 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, memory byte width.
- WAIT_STATES, 0, extra cycles the bus is held per byte access; legal range 0-15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE and with resetn=1 (combinational)
- req_write  in  1  1=byte write, 0=read
- req_word  in  1  1=16-bit read of addr, addr+1; ignored when req_write=1
- req_page_wrap  in  1  word read: high byte address = {addr[15:8], addr[7:0]+1}
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  2*DATA_WIDTH  {hi,lo}; byte read {8'h00,lo}; write 16'h0000
- mem_enable  out  1  memory enable
- mem_address  out  ADDR_WIDTH  memory address
- mem_wr_enable  out  1  memory write strobe
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  memory read data; the memory returns 8'hFF when disabled

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, wait counter=0.
  - mem_enable=0, mem_wr_enable=0, mem_address=0, mem_wr_data=0.
  - rsp_valid=0, rsp_rdata=0.
  - req_ready=0 while resetn=0.
- Reset mid-operation aborts the access. No rsp_valid is produced, the partial word is discarded, and outputs take their reset values after that edge.
- All mem_* and rsp_* outputs are registered.
- States: IDLE, ACC_LO, ACC_HI.
- IDLE:
  - Handshake fires at edge E0 when req_valid and req_ready are both high.
  - At E0 the controller latches addr, write, word, page_wrap and wdata.
  - It sets mem_enable=1, mem_address=req_addr, mem_wr_enable=req_write, mem_wr_data=req_wdata, counter=0, and moves to ACC_LO.
- ACC_LO / ACC_HI (one byte access each):
  - Bus is held constant for 2+WAIT_STATES cycles: the counter increments each edge, and the access ends at the edge where counter==1+WAIT_STATES.
  - The memory samples the address at E0+1. The controller samples mem_rd_data at the ending edge E0+2+WAIT_STATES.
  - Write: memory writes at E0+1. At the ending edge: mem_enable=0, mem_wr_enable=0, rsp_valid=1, rsp_rdata=0, go to IDLE.
  - Byte read: at the ending edge, lo<=mem_rd_data, rsp_rdata={8'h00,mem_rd_data}, rsp_valid=1, mem_enable=0, go to IDLE.
  - Word read, end of ACC_LO: lo<=mem_rd_data; mem_address<=page_wrap ? {addr[15:8],addr[7:0]+1} : addr+1 (mod 2**ADDR_WIDTH, so 0xFFFF becomes 0x0000); counter=0; mem_enable stays 1; go to ACC_HI.
  - End of ACC_HI: rsp_rdata={mem_rd_data,lo}, rsp_valid=1, mem_enable=0, go to IDLE.
- Latency, accept edge to rsp_valid-setting edge:
  - byte: 2+WAIT_STATES
  - word: 4+2*WAIT_STATES
- Throughput: req_ready rises the cycle after rsp_valid is set, so the next accept is at the earliest one edge later. Back-to-back byte reads with W=0 give one response per 3 cycles.
- rsp_valid is high exactly one cycle and has no backpressure. rsp_rdata holds until the next response.
- In IDLE, mem_address and mem_wr_data hold their last values and mem_enable=0.
- req_* inputs are ignored outside an accepting edge.

Test Plan:
- Byte read, W=0, mem[0x1234]=0xA5: accept at E0 -> mem_enable=1 and mem_address=0x1234 after E0; rsp_valid=1 with rsp_rdata=0x00A5 in the cycle after E0+2; mem_enable=0 in that same cycle.
- Word read of 0xFFFC, mem[0xFFFC]=0x00, mem[0xFFFD]=0x80, W=0 -> mem_address sequence 0xFFFC then 0xFFFD; rsp_rdata=0x8000 set at E0+4; single rsp_valid pulse.
- Page wrap at 0x30FF, mem[0x30FF]=0x11, mem[0x3000]=0x22, mem[0x3100]=0x33:
  - req_page_wrap=1 -> 0x2211.
  - req_page_wrap=0 -> 0x3311.
  - Word read at 0xFFFF (page_wrap=0) reads its high byte from 0x0000.
- Write then read back: write 0x5A to 0x0200 -> mem_wr_enable=1 for 2 cycles and rsp_valid with rdata 0x0000; the following byte read of 0x0200 returns 0x005A.
- WAIT_STATES=3: byte read rsp_valid set at E0+5, word read at E0+10; bus held stable and req_ready=0 throughout.
- resetn=0 during ACC_HI of a word read -> no rsp_valid; after that edge mem_enable=0, mem_address=0 and req_ready=0. After release, req_ready=1 and a new byte read returns correct data.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Bus-side memory controller for the 6502 core: byte read/write and 16-bit little-endian word
// reads against a registered-read memory, with programmable wait states per byte access.
module mem_bus_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_write,
   input  logic                    i_req_word,
   input  logic                    i_req_page_wrap,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   output logic                    o_rsp_valid,
   output logic [2*DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                    o_mem_enable,
   output logic [ADDR_WIDTH-1:0]   o_mem_address,
   output logic                    o_mem_wr_enable,
   output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
   input  logic [DATA_WIDTH-1:0]   i_mem_rd_data
);

   typedef enum logic [1:0] {StIdle, StAccLo, StAccHi} state_e;

   localparam logic [4:0] CntLast = 5'(WAIT_STATES + 1);

   state_e                  r_state, w_state_next;
   logic [4:0]              r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_write;
   logic                    r_word;
   logic                    r_page_wrap;
   logic [DATA_WIDTH-1:0]   r_lo;

   logic                    w_accept;
   logic                    w_last;
   logic [ADDR_WIDTH-1:0]   w_hi_addr;

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StAccLo;
         StAccLo: if (w_last) w_state_next = r_word ? StAccHi : StIdle;
         StAccHi: if (w_last) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_req_ready = (r_state == StIdle) && resetn;
      w_accept    = o_req_ready && i_req_valid;
      w_last      = (r_state != StIdle) && (r_cnt == CntLast);
      // Page wrap keeps the high address byte and rolls only the low byte.
      w_hi_addr   = r_page_wrap ? {r_addr[ADDR_WIDTH-1:8], r_addr[7:0] + 8'd1}
                                : r_addr + ADDR_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt           <= '0;
         r_addr          <= '0;
         r_write         <= 1'b0;
         r_word          <= 1'b0;
         r_page_wrap     <= 1'b0;
         r_lo            <= '0;
         o_rsp_valid     <= 1'b0;
         o_rsp_rdata     <= '0;
         o_mem_enable    <= 1'b0;
         o_mem_address   <= '0;
         o_mem_wr_enable <= 1'b0;
         o_mem_wr_data   <= '0;
      end else begin
         o_rsp_valid <= 1'b0;
         if (w_accept) begin
            r_addr          <= i_req_addr;
            r_write         <= i_req_write;
            r_word          <= i_req_word & ~i_req_write;
            r_page_wrap     <= i_req_page_wrap;
            r_cnt           <= '0;
            o_mem_enable    <= 1'b1;
            o_mem_address   <= i_req_addr;
            o_mem_wr_enable <= i_req_write;
            o_mem_wr_data   <= i_req_wdata;
         end else if (r_state != StIdle) begin
            if (!w_last) begin
               r_cnt <= r_cnt + 5'd1;
            end else if (r_state == StAccLo && r_word) begin
               // Low byte of a word read: keep the bus enabled and move to the high byte.
               r_cnt         <= '0;
               r_lo          <= i_mem_rd_data;
               o_mem_address <= w_hi_addr;
            end else begin
               r_cnt           <= '0;
               o_mem_enable    <= 1'b0;
               o_mem_wr_enable <= 1'b0;
               o_rsp_valid     <= 1'b1;
               if (r_write) begin
                  o_rsp_rdata <= '0;
               end else if (r_state == StAccHi) begin
                  o_rsp_rdata <= {i_mem_rd_data, r_lo};
               end else begin
                  r_lo        <= i_mem_rd_data;
                  o_rsp_rdata <= {{DATA_WIDTH{1'b0}}, i_mem_rd_data};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: one instance with no wait states and one with three,
// sharing a registered-read memory model and a reference byte array.
module tb_mem_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        sel;
   logic        req_valid, req_write, req_word, req_page_wrap;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;

   logic        rdy0, rdy3, rv0, rv3, en0, en3, we0, we3;
   logic [15:0] rd0, rd3, ad0, ad3;
   logic [7:0]  wd0, wd3, mrd0, mrd3;

   logic        req_ready, rsp_valid, mem_enable, mem_wr_enable;
   logic [15:0] rsp_rdata, mem_address;
   logic [7:0]  mem_wr_data;

   assign req_ready     = sel ? rdy3 : rdy0;
   assign rsp_valid     = sel ? rv3 : rv0;
   assign rsp_rdata     = sel ? rd3 : rd0;
   assign mem_enable    = sel ? en3 : en0;
   assign mem_address   = sel ? ad3 : ad0;
   assign mem_wr_enable = sel ? we3 : we0;
   assign mem_wr_data   = sel ? wd3 : wd0;

   mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .resetn(resetn), .i_req_valid(req_valid & ~sel), .o_req_ready(rdy0),
      .i_req_write(req_write), .i_req_word(req_word), .i_req_page_wrap(req_page_wrap),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rv0), .o_rsp_rdata(rd0),
      .o_mem_enable(en0), .o_mem_address(ad0), .o_mem_wr_enable(we0), .o_mem_wr_data(wd0),
      .i_mem_rd_data(mrd0)
   );

   mem_bus_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(3)) dut3 (
      .clk(clk), .resetn(resetn), .i_req_valid(req_valid & sel), .o_req_ready(rdy3),
      .i_req_write(req_write), .i_req_word(req_word), .i_req_page_wrap(req_page_wrap),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rv3), .o_rsp_rdata(rd3),
      .o_mem_enable(en3), .o_mem_address(ad3), .o_mem_wr_enable(we3), .o_mem_wr_data(wd3),
      .i_mem_rd_data(mrd3)
   );

   // Memory: registered read, 8'hFF when disabled, plus a preload port for the bench.
   logic [7:0]  mem [65536];
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (en0) begin
         if (we0) mem[ad0] <= wd0;
         mrd0 <= mem[ad0];
      end else mrd0 <= 8'hFF;
      if (en3) begin
         if (we3) mem[ad3] <= wd3;
         mrd3 <= mem[ad3];
      end else mrd3 <= 8'hFF;
   end

   logic [7:0] ref_mem [65536];
   bit         known [65536];
   int         n_cmp = 0;
   int         n_err = 0;

   // Observations of the last transaction and model expectations.
   int          t_lat, t_pulses, t_chg, t_busy, t_wrc;
   logic [15:0] t_rdata, t_first_a, t_last_a;
   logic        t_first_en, t_en_rsp, t_rdy_rsp, t_held;
   int          e_lat, e_chg, e_wrc;
   logic [15:0] e_rd, e_last;

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
      ref_mem[a] = d;
      known[a]   = 1'b1;
   endtask

   task automatic ensure(input logic [15:0] a);
      if (!known[a]) poke(a, 8'($urandom));
   endtask

   function automatic logic [15:0] hi_of(input logic [15:0] a, input logic pw);
      logic [15:0] h;
      h = a + 16'd1;
      if (pw) h = {a[15:8], h[7:0]};
      return h;
   endfunction

   task automatic model(input logic wr, input logic wd, input logic pw, input logic [15:0] a,
                        input logic [7:0] wdat, input int w);
      logic [15:0] h;
      if (wr) begin
         ref_mem[a] = wdat; known[a] = 1'b1;
         e_rd = 16'h0000; e_lat = 2 + w; e_chg = 0; e_last = a; e_wrc = 2 + w;
      end else if (wd) begin
         h = hi_of(a, pw);
         e_rd = {ref_mem[h], ref_mem[a]}; e_lat = 4 + 2 * w; e_chg = 1; e_last = h; e_wrc = 0;
      end else begin
         e_rd = {8'h00, ref_mem[a]}; e_lat = 2 + w; e_chg = 0; e_last = a; e_wrc = 0;
      end
   endtask

   task automatic run_txn(input logic wr, input logic wd, input logic pw, input logic [15:0] a,
                          input logic [7:0] wdat);
      int guard;
      @(negedge clk);
      req_write = wr; req_word = wd; req_page_wrap = pw; req_addr = a; req_wdata = wdat;
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Junk on the request fields must be ignored while busy.
      req_addr = 16'($urandom); req_write = 1'($urandom); req_word = 1'($urandom);
      req_wdata = 8'($urandom);
      t_first_en = mem_enable; t_first_a = mem_address; t_last_a = mem_address;
      t_lat = -1; t_pulses = 0; t_chg = 0; t_busy = 0; t_wrc = 0; t_held = 1'b1;
      t_rdata = 16'hxxxx; t_en_rsp = 1'bx; t_rdy_rsp = 1'bx;
      for (int k = 1; k <= 40 && t_lat < 0; k++) begin
         if (mem_wr_enable) t_wrc++;
         if (req_ready) t_busy++;
         @(posedge clk); #1;
         if (mem_address !== t_last_a) begin
            t_chg++;
            t_last_a = mem_address;
         end
         if (rsp_valid === 1'b1) begin
            t_lat = k; t_pulses = 1; t_rdata = rsp_rdata;
            t_en_rsp = mem_enable; t_rdy_rsp = req_ready;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) t_pulses++;
         if (rsp_rdata !== t_rdata) t_held = 1'b0;
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (mem_enable !== 1'b0) begin
         n_err++; $display("FAIL reset_en: got %b want 0", mem_enable); end
      n_cmp++; if (mem_wr_enable !== 1'b0) begin
         n_err++; $display("FAIL reset_we: got %b want 0", mem_wr_enable); end
      n_cmp++; if (mem_address !== 16'h0000) begin
         n_err++; $display("FAIL reset_addr: got %h want 0000", mem_address); end
      n_cmp++; if (mem_wr_data !== 8'h00) begin
         n_err++; $display("FAIL reset_wdata: got %h want 00", mem_wr_data); end
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin
         n_err++; $display("FAIL reset_rsp: got %b/%h want 0/0000", rsp_valid, rsp_rdata); end
      n_cmp++; if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin
         n_err++; $display("FAIL reset_ready: got %b%b want 00", rdy0, rdy3); end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
         n_err++; $display("FAIL release_ready: got %b%b want 11", rdy0, rdy3); end
   endtask

   task automatic test_byte_read;
      sel = 1'b0;
      poke(16'h1234, 8'hA5);
      run_txn(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00);
      n_cmp++; if (t_first_en !== 1'b1 || t_first_a !== 16'h1234) begin
         n_err++; $display("FAIL byte_bus: got en=%b a=%h want 1/1234", t_first_en, t_first_a); end
      n_cmp++; if (t_lat !== 2) begin
         n_err++; $display("FAIL byte_lat: got %0d want 2", t_lat); end
      n_cmp++; if (t_rdata !== 16'h00A5) begin
         n_err++; $display("FAIL byte_data: got %h want 00a5", t_rdata); end
      n_cmp++; if (t_en_rsp !== 1'b0 || t_rdy_rsp !== 1'b1) begin
         n_err++; $display("FAIL byte_rsp_cycle: got en=%b rdy=%b want 0/1", t_en_rsp, t_rdy_rsp);
      end
      n_cmp++; if (t_pulses !== 1 || t_busy !== 0) begin
         n_err++; $display("FAIL byte_pulse: got %0d pulses %0d busy want 1/0", t_pulses, t_busy);
      end
   endtask

   task automatic test_word_read;
      sel = 1'b0;
      poke(16'hFFFC, 8'h00);
      poke(16'hFFFD, 8'h80);
      run_txn(1'b0, 1'b1, 1'b0, 16'hFFFC, 8'h00);
      n_cmp++; if (t_first_a !== 16'hFFFC || t_last_a !== 16'hFFFD || t_chg !== 1) begin
         n_err++; $display("FAIL word_addr: got %h->%h (%0d) want fffc->fffd",
                           t_first_a, t_last_a, t_chg); end
      n_cmp++; if (t_rdata !== 16'h8000 || t_lat !== 4) begin
         n_err++; $display("FAIL word_data: got %h lat %0d want 8000 lat 4", t_rdata, t_lat); end
      n_cmp++; if (t_pulses !== 1 || !t_held) begin
         n_err++; $display("FAIL word_pulse: got %0d held %b want 1/1", t_pulses, t_held); end
   endtask

   task automatic test_page_wrap;
      sel = 1'b0;
      poke(16'h30FF, 8'h11); poke(16'h3000, 8'h22); poke(16'h3100, 8'h33);
      poke(16'hFFFF, 8'h44); poke(16'h0000, 8'h55);
      run_txn(1'b0, 1'b1, 1'b1, 16'h30FF, 8'h00);
      n_cmp++; if (t_rdata !== 16'h2211 || t_last_a !== 16'h3000) begin
         n_err++; $display("FAIL wrap_on: got %h @%h want 2211 @3000", t_rdata, t_last_a); end
      run_txn(1'b0, 1'b1, 1'b0, 16'h30FF, 8'h00);
      n_cmp++; if (t_rdata !== 16'h3311 || t_last_a !== 16'h3100) begin
         n_err++; $display("FAIL wrap_off: got %h @%h want 3311 @3100", t_rdata, t_last_a); end
      run_txn(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h00);
      n_cmp++; if (t_rdata !== 16'h5544 || t_last_a !== 16'h0000) begin
         n_err++; $display("FAIL wrap_top: got %h @%h want 5544 @0000", t_rdata, t_last_a); end
   endtask

   task automatic test_write_read;
      sel = 1'b0;
      run_txn(1'b1, 1'b0, 1'b0, 16'h0200, 8'h5A);
      ref_mem[16'h0200] = 8'h5A; known[16'h0200] = 1'b1;
      n_cmp++; if (t_wrc !== 2 || t_rdata !== 16'h0000 || t_lat !== 2) begin
         n_err++; $display("FAIL write: got we_cycles=%0d rdata=%h lat=%0d want 2/0000/2",
                           t_wrc, t_rdata, t_lat); end
      run_txn(1'b0, 1'b0, 1'b0, 16'h0200, 8'h00);
      n_cmp++; if (t_rdata !== 16'h005A) begin
         n_err++; $display("FAIL readback: got %h want 005a", t_rdata); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] addrs [4];
      int idx, n_rsp, last_cyc;
      logic acc;
      sel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addrs[i] = 16'h4000 + 16'(i * 37);
         ensure(addrs[i]);
      end
      @(negedge clk);
      req_write = 1'b0; req_word = 1'b0; req_addr = addrs[0]; req_valid = 1'b1;
      idx = 0; n_rsp = 0; last_cyc = 0;
      for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
         acc = req_ready && req_valid;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) req_addr = addrs[idx];
            else req_valid = 1'b0;
         end
         if (rsp_valid === 1'b1) begin
            n_cmp++; if (rsp_rdata !== {8'h00, ref_mem[addrs[n_rsp]]}) begin
               n_err++; $display("FAIL b2b_data%0d: got %h want %h", n_rsp, rsp_rdata,
                                 {8'h00, ref_mem[addrs[n_rsp]]}); end
            if (n_rsp > 0) begin
               n_cmp++; if (cyc - last_cyc !== 3) begin
                  n_err++; $display("FAIL b2b_gap%0d: got %0d want 3", n_rsp, cyc - last_cyc); end
            end
            last_cyc = cyc;
            n_rsp++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_cmp++; if (n_rsp !== 4) begin
         n_err++; $display("FAIL b2b_count: got %0d want 4", n_rsp); end
   endtask

   task automatic test_wait_states;
      sel = 1'b1;
      poke(16'h0777, 8'hC3); poke(16'h07FF, 8'h9E); poke(16'h0800, 8'h61);
      run_txn(1'b0, 1'b0, 1'b0, 16'h0777, 8'h00);
      n_cmp++; if (t_lat !== 5 || t_rdata !== 16'h00C3 || t_busy !== 0 || t_chg !== 0) begin
         n_err++; $display("FAIL ws_byte: got lat=%0d d=%h busy=%0d chg=%0d want 5/00c3/0/0",
                           t_lat, t_rdata, t_busy, t_chg); end
      run_txn(1'b0, 1'b1, 1'b0, 16'h07FF, 8'h00);
      n_cmp++; if (t_lat !== 10 || t_rdata !== 16'h619E || t_busy !== 0 || t_chg !== 1) begin
         n_err++; $display("FAIL ws_word: got lat=%0d d=%h busy=%0d chg=%0d want 10/619e/0/1",
                           t_lat, t_rdata, t_busy, t_chg); end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic saw;
      int guard;
      sel = 1'b0;
      poke(16'h5550, 8'h3C); poke(16'h5551, 8'hD7);
      @(negedge clk);
      req_write = 1'b0; req_word = 1'b1; req_page_wrap = 1'b0; req_addr = 16'h5550;
      req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      saw = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         saw |= (rsp_valid === 1'b1);
      end
      resetn = 1'b0;
      @(posedge clk); #1;
      saw |= (rsp_valid !== 1'b0);
      n_cmp++; if (mem_enable !== 1'b0 || mem_address !== 16'h0000 || req_ready !== 1'b0) begin
         n_err++; $display("FAIL abort_bus: got en=%b a=%h rdy=%b want 0/0000/0",
                           mem_enable, mem_address, req_ready); end
      @(posedge clk); #1;
      saw |= (rsp_valid !== 1'b0);
      n_cmp++; if (saw !== 1'b0) begin
         n_err++; $display("FAIL abort_rsp: got rsp_valid seen=%b want 0", saw); end
      resetn = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL abort_ready: got %b want 1", req_ready); end
      run_txn(1'b0, 1'b0, 1'b0, 16'h5551, 8'h00);
      n_cmp++; if (t_rdata !== 16'h00D7 || t_lat !== 2) begin
         n_err++; $display("FAIL abort_next: got %h lat %0d want 00d7 lat 2", t_rdata, t_lat); end
   endtask

   task automatic test_random;
      logic wr, wd, pw;
      logic [15:0] a;
      logic [7:0] wdat;
      int w;
      for (int n = 0; n < 30; n++) begin
         sel  = 1'($urandom);
         w    = sel ? 3 : 0;
         wr   = ($urandom_range(3) == 0);
         wd   = 1'($urandom);
         pw   = 1'($urandom);
         a    = 16'($urandom);
         wdat = 8'($urandom);
         if ($urandom_range(2) == 0) a[7:0] = 8'hFF;
         ensure(a);
         ensure(hi_of(a, pw));
         model(wr, wd, pw, a, wdat, w);
         run_txn(wr, wd, pw, a, wdat);
         n_cmp++; if (t_lat !== e_lat || t_rdata !== e_rd) begin
            n_err++; $display("FAIL rand%0d_rsp: got %h lat %0d want %h lat %0d",
                              n, t_rdata, t_lat, e_rd, e_lat); end
         n_cmp++; if (t_first_a !== a || t_last_a !== e_last || t_chg !== e_chg) begin
            n_err++; $display("FAIL rand%0d_addr: got %h->%h (%0d) want %h->%h (%0d)",
                              n, t_first_a, t_last_a, t_chg, a, e_last, e_chg); end
         n_cmp++; if (t_wrc !== e_wrc || t_busy !== 0 || t_pulses !== 1 || !t_held) begin
            n_err++; $display("FAIL rand%0d_ctl: got we=%0d busy=%0d pulses=%0d held=%b",
                              n, t_wrc, t_busy, t_pulses, t_held); end
      end
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_page_wrap = 1'b0;
      req_addr = 16'h0000; req_wdata = 8'h00; pl_en = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;
      test_reset();
      test_byte_read();
      test_word_read();
      test_page_wrap();
      test_write_read();
      test_back_to_back();
      test_wait_states();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
